hilo_unit: RTL and testbench

//  Architectural HI/LO register pair sitting directly downstream of the ALU's high/low outputs.

---
 rtl/mips_hilo_pkg.sv | 31 +++
 rtl/hilo_unit_if.sv | 28 ++
 rtl/hilo_lat_counter.sv | 30 +++
 rtl/hilo_unit.sv | 123 ++++++++++++
 tb/tb_hilo_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mips_hilo_pkg.sv
// Shared types and helpers for the HI/LO unit.
//   hilo_op_t    : 4-bit request opcode
//   hilo_state_t : HI/LO FSM state encoding
//   HILO_LAT_W   : width of the latency counter (latencies 1..15)
//   is_muldiv()  : true for MULT/MULTU/DIV/DIVU
package mips_hilo_pkg;

    localparam int HILO_LAT_W = 4;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } hilo_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } hilo_state_t;

    function automatic logic is_muldiv(input hilo_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_unit_if.sv
// Request/response bundle between the pipeline and the HI/LO unit.
//   master : pipeline side (drives op_valid/op/operands, sees results)
//   slave  : HI/LO unit side
import mips_hilo_pkg::*;

interface hilo_unit_if;
    logic        op_valid;
    hilo_op_t    op;
    logic [31:0] alu_high;
    logic [31:0] alu_low;
    logic [31:0] divisor;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        stall;
    logic        busy;
    logic        div_by_zero;

    modport master (
        output op_valid, op, alu_high, alu_low, divisor, wdata,
        input  rdata, rdata_valid, stall, busy, div_by_zero
    );

    modport slave (
        input  op_valid, op, alu_high, alu_low, divisor, wdata,
        output rdata, rdata_valid, stall, busy, div_by_zero
    );
endinterface

// File: rtl/hilo_lat_counter.sv
// Latency down-counter for pending mult/div results.
//   clk, reset_n : clock, async active-low reset
//   i_load       : load i_load_val (takes priority over decrement)
//   i_load_val   : value loaded, LAT-1
//   i_dec        : decrement request; saturates at zero
//   o_zero       : terminal count reached
import mips_hilo_pkg::*;

module hilo_lat_counter (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic [HILO_LAT_W-1:0] i_load_val,
    input  logic                  i_dec,
    output logic                  o_zero
);
    logic [HILO_LAT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO register pair with modelled mult/div latency.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : op request, ALU high/low results, divisor, wdata;
//                  rdata/rdata_valid, stall, busy, div_by_zero
// Parameters: MULT_LAT, DIV_LAT (1..15) cycles from accept to commit.
// Build option: HILO_FORWARD_EN lets MFHI/MFLO read the shadow
// registers in the commit cycle instead of stalling one more cycle.
//
// state   | meaning
// --------+------------------------------------------------------
// ST_IDLE | no result pending; HI/LO are current
// ST_BUSY | shadow holds a pending result; commits when count==0
import mips_hilo_pkg::*;

module hilo_unit #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 12
) (
    input  logic      clk,
    input  logic      reset_n,
    hilo_unit_if.slave bus
);
    localparam logic [HILO_LAT_W-1:0] MULT_LD = HILO_LAT_W'(MULT_LAT - 1);
    localparam logic [HILO_LAT_W-1:0] DIV_LD  = HILO_LAT_W'(DIV_LAT - 1);

    hilo_state_t r_state;
    hilo_state_t w_next_state;
    logic [31:0] r_hi, r_lo, r_shadow_hi, r_shadow_lo;

    logic w_busy, w_cnt_zero, w_fwd_ok, w_stall, w_accept;
    logic w_is_md, w_is_div, w_is_mult, w_is_mt, w_is_mf;
    logic w_dbz, w_start, w_commit;
    logic [HILO_LAT_W-1:0] w_load_val;

    assign w_is_md   = is_muldiv(bus.op);
    assign w_is_mult = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign w_is_div  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign w_is_mt   = (bus.op == OP_MTHI) || (bus.op == OP_MTLO);
    assign w_is_mf   = (bus.op == OP_MFHI) || (bus.op == OP_MFLO);

    assign w_busy   = (r_state == ST_BUSY);
    assign w_commit = w_busy && w_cnt_zero;

`ifdef HILO_FORWARD_EN
    assign w_fwd_ok = w_cnt_zero;
`else
    assign w_fwd_ok = 1'b0;
`endif

    assign w_stall  = bus.op_valid && w_busy &&
                      ((w_is_md || w_is_mt) || (w_is_mf && !w_fwd_ok));
    assign w_accept = bus.op_valid && !w_stall;
    // A zero-divisor divide is consumed here and never reaches BUSY.
    assign w_dbz    = w_accept && w_is_div && (bus.divisor == 32'd0);
    assign w_start  = w_accept && w_is_md && !w_dbz;
    assign w_load_val = w_is_mult ? MULT_LD : DIV_LD;

    hilo_lat_counter u_lat (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_start),
        .i_load_val (w_load_val),
        .i_dec      (w_busy),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start)    w_next_state = ST_BUSY;
            ST_BUSY: if (w_cnt_zero) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // MTHI/MTLO always stall while busy, so they never collide with a commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi        <= '0;
            r_lo        <= '0;
            r_shadow_hi <= '0;
            r_shadow_lo <= '0;
        end else begin
            if (w_start) begin
                r_shadow_hi <= bus.alu_high;
                r_shadow_lo <= bus.alu_low;
            end
            if (w_commit) begin
                r_hi <= r_shadow_hi;
                r_lo <= r_shadow_lo;
            end else if (w_accept && (bus.op == OP_MTHI)) begin
                r_hi <= bus.wdata;
            end else if (w_accept && (bus.op == OP_MTLO)) begin
                r_lo <= bus.wdata;
            end
        end
    end

    // An accepted read while busy can only be the forwarded commit-cycle case.
    always_comb begin
        bus.rdata = 32'd0;
        if (w_accept && w_is_mf) begin
            if (w_busy) begin
                bus.rdata = (bus.op == OP_MFHI) ? r_shadow_hi : r_shadow_lo;
            end else begin
                bus.rdata = (bus.op == OP_MFHI) ? r_hi : r_lo;
            end
        end
    end

    assign bus.rdata_valid = w_accept && w_is_mf;
    assign bus.stall       = w_stall;
    assign bus.busy        = w_busy;
    assign bus.div_by_zero = w_dbz;
endmodule

// File: tb/tb_hilo_unit.sv
import mips_hilo_pkg::*;

module tb_hilo_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hilo_unit_if bus();

    hilo_unit #(.MULT_LAT(4), .DIV_LAT(12)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

`ifdef HILO_FORWARD_EN
    localparam int MF_STALLS = 3;
`else
    localparam int MF_STALLS = 4;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented read is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset_n && bus.rdata_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %h expected no read", bus.rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk(e.name, bus.rdata, e.val);
            end
        end
    end

    // Drive one request and hold it until accepted; called #1 after a posedge.
    task automatic do_op(input string name, input hilo_op_t o,
                         input logic [31:0] ah, input logic [31:0] al,
                         input logic [31:0] dv, input logic [31:0] wd,
                         input logic [31:0] exp_rd,
                         output int stalls, output logic dbz);
        stalls = 0;
        dbz = 1'b0;
        if ((o == OP_MFHI) || (o == OP_MFLO)) exp_q.push_back('{name, exp_rd});
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.alu_high = ah;
        bus.alu_low  = al;
        bus.divisor  = dv;
        bus.wdata    = wd;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus.stall) begin
                dbz = bus.div_by_zero;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        if (stalls >= 50) chk({name, "_timeout"}, 32'(stalls), 32'd0);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.op       = OP_NOP;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    int   st;
    int   nb;
    logic dz;

    initial begin
        bus.op_valid = 1'b0;
        bus.op       = OP_NOP;
        bus.alu_high = '0;
        bus.alu_low  = '0;
        bus.divisor  = '0;
        bus.wdata    = '0;

        #2;
        chk("rst_rdata",       bus.rdata,       32'd0);
        chk("rst_rdata_valid", 32'(bus.rdata_valid), 32'd0);
        chk("rst_stall",       32'(bus.stall),  32'd0);
        chk("rst_busy",        32'(bus.busy),   32'd0);
        chk("rst_dbz",         32'(bus.div_by_zero), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_op("rd_hi_after_reset", OP_MFHI, 0, 0, 0, 0, 32'd0, st, dz);

        // 1: MULT latency and commit
        do_op("t1_mult", OP_MULT, 32'h1, 32'hFFFF_FFFE, 32'd1, 0, 0, st, dz);
        count_busy(nb);
        chk("t1_busy_cycles", 32'(nb), 32'd4);
        do_op("t1_hi", OP_MFHI, 0, 0, 0, 0, 32'h1, st, dz);
        do_op("t1_lo", OP_MFLO, 0, 0, 0, 0, 32'hFFFF_FFFE, st, dz);

        // 2: MFLO immediately after MULT
        do_op("t2_mult", OP_MULTU, 32'h0000_1234, 32'hCAFE_0001, 32'd1, 0, 0, st, dz);
        do_op("t2_mflo", OP_MFLO, 0, 0, 0, 0, 32'hCAFE_0001, st, dz);
        chk("t2_stall_cycles", 32'(st), 32'(MF_STALLS));
        @(posedge clk); #1;
        do_op("t2_hi", OP_MFHI, 0, 0, 0, 0, 32'h0000_1234, st, dz);

        // 3: divide by zero
        do_op("t3_divu0", OP_DIVU, 32'h5555_5555, 32'hAAAA_AAAA, 32'd0, 0, 0, st, dz);
        chk("t3_dbz_pulse", 32'(dz), 32'd1);
        chk("t3_dbz_no_stall", 32'(st), 32'd0);
        @(negedge clk);
        chk("t3_dbz_clears", 32'(bus.div_by_zero), 32'd0);
        chk("t3_not_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        do_op("t3_hi", OP_MFHI, 0, 0, 0, 0, 32'h0000_1234, st, dz);
        do_op("t3_lo", OP_MFLO, 0, 0, 0, 0, 32'hCAFE_0001, st, dz);

        // 4: MTHI then MFHI
        do_op("t4_mthi", OP_MTHI, 0, 0, 0, 32'hDEAD_BEEF, 0, st, dz);
        do_op("t4_hi", OP_MFHI, 0, 0, 0, 0, 32'hDEAD_BEEF, st, dz);
        chk("t4_hi_no_stall", 32'(st), 32'd0);
        do_op("t4_lo", OP_MFLO, 0, 0, 0, 0, 32'hCAFE_0001, st, dz);
        do_op("t4_mtlo", OP_MTLO, 0, 0, 0, 32'h0BAD_F00D, 0, st, dz);
        do_op("t4_lo2", OP_MFLO, 0, 0, 0, 0, 32'h0BAD_F00D, st, dz);
        do_op("t4_hi2", OP_MFHI, 0, 0, 0, 0, 32'hDEAD_BEEF, st, dz);

        // 5: reset mid-divide (count 11 after accept, 5 after six more edges)
        do_op("t5_div", OP_DIV, 32'h7777_7777, 32'h8888_8888, 32'd3, 0, 0, st, dz);
        repeat (6) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t5_busy_cleared", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_op("t5_lo", OP_MFLO, 0, 0, 0, 0, 32'd0, st, dz);
        chk("t5_lo_no_stall", 32'(st), 32'd0);
        do_op("t5_hi", OP_MFHI, 0, 0, 0, 0, 32'd0, st, dz);

        // 6: MULT then DIV back-to-back
        do_op("t6_mult", OP_MULT, 32'h1111_1111, 32'h2222_2222, 32'd1, 0, 0, st, dz);
        do_op("t6_div", OP_DIV, 32'h0000_0003, 32'h0000_0007, 32'd5, 0, 0, st, dz);
        chk("t6_div_stalls", 32'(st), 32'd4);
        count_busy(nb);
        chk("t6_div_busy", 32'(nb), 32'd12);
        do_op("t6_hi", OP_MFHI, 0, 0, 0, 0, 32'h0000_0003, st, dz);
        do_op("t6_lo", OP_MFLO, 0, 0, 0, 0, 32'h0000_0007, st, dz);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
